instr_fetch: RTL
================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 The block SHALL have parameter PC_W, default 10, meaning the program counter and instruction-memory address width.
REQ-002 The block SHALL have parameter IW, default 9, meaning the machine-code word width.
REQ-003 The block SHALL have parameter LUT_N, default 32, meaning the number of branch-target LUT entries, indexed by 5 bits.
REQ-004 Port clk, input, 1, is the single clock; all state SHALL update on its rising edge.
REQ-005 Port reset, input, 1, is asynchronous and active-high.
REQ-006 Port start, input, 1, is a one-cycle request to begin execution at address 0.
REQ-007 Port stall, input, 1, holds all fetch state for the cycle it is high.
REQ-008 Port branch, input, 1, is the branch indication for the currently presented instr.
REQ-009 Port taken, input, 1, is the branch condition result for the currently presented instr.
REQ-010 Port target_idx, input, 5, is the branch-target LUT index taken from the presented instr.
REQ-011 Port lut_we, input, 1, is the branch-target LUT write enable.
REQ-012 Port lut_waddr, input, 5, is the LUT write index.
REQ-013 Port lut_wdata, input, PC_W, is the LUT write data.
REQ-014 Port imem_addr, output, PC_W, is the instruction-memory address; it SHALL equal pc combinationally.
REQ-015 Port imem_data, input, IW, is the combinational instruction-memory read data at imem_addr.
REQ-016 Port instr, output, IW, is the registered machine code presented to the decoder.
REQ-017 Port instr_valid, output, 1, is high when instr holds an instruction to execute this cycle.
REQ-018 Port pc, output, PC_W, is the address of the next word to fetch.
REQ-019 Port done, output, 1, is high while the block is in HALT.
REQ-020 Port cycle_cnt, output, 16, is the count of non-stalled RUN cycles.

Function
REQ-021 The FSM SHALL have states IDLE, RUN and HALT.
REQ-022 In IDLE or HALT, start=1 SHALL set pc=0, instr_valid=0, done=0 and cycle_cnt=0, and enter RUN; in RUN, start SHALL be ignored.
REQ-023 In RUN with stall=0, the block SHALL load instr<=imem_data, set instr_valid<=1, set pc<=pc+1 (wrapping 2^PC_W-1 to 0) and increment cycle_cnt, saturating at 16'hFFFF.
REQ-024 In RUN with stall=1, pc, instr, instr_valid, state and cycle_cnt SHALL hold; branch, taken and the halt check SHALL be ignored that cycle.
REQ-025 In RUN with stall=0 and instr_valid=1, branch=1 and taken=1, the block SHALL set pc<=LUT[target_idx] and instr_valid<=0, squashing the word fetched that cycle.
REQ-026 branch=1 with taken=0 SHALL behave as sequential fetch.
REQ-027 branch/taken SHALL be ignored when instr_valid=0.
REQ-028 A halt word is one with instr[8:4]=5'b11111.
REQ-029 In RUN with stall=0, when instr_valid=1 and instr is a halt word, the block SHALL enter HALT, set instr_valid<=0 and done<=1, and hold pc; halt SHALL take priority over branch.
REQ-030 In IDLE and HALT, pc, instr and cycle_cnt SHALL hold.
REQ-031 In IDLE and HALT, instr_valid SHALL be 0.
REQ-032 LUT writes SHALL be accepted in any state, including during stall.
REQ-033 A same-cycle LUT write and branch read of the same entry SHALL use the old LUT value.
REQ-034 Fetch latency SHALL be 1 cycle from imem_addr to instr.
REQ-035 The taken-branch penalty SHALL be 1 bubble cycle.

Reset
REQ-036 reset=1 SHALL asynchronously force state=IDLE, pc=0, instr=0, instr_valid=0, done=0, cycle_cnt=0 and all LUT entries=0.
REQ-037 Reset asserted mid-RUN SHALL abort execution immediately, with no pending branch or halt surviving.
REQ-038 After reset deasserts, the block SHALL stay in IDLE until start.

Verification
REQ-039 Bench scenario, sequential fetch: ROM[0..3]=9'h001,002,003,004 and start pulse -> instr=001,002,003,004 on consecutive cycles with instr_valid=1, pc=1..4, cycle_cnt=4.
REQ-040 Bench scenario, taken branch: LUT[3]=10'h020 and a branch at addr 2 with taken=1, target_idx=3 -> one instr_valid=0 bubble, then instr=ROM[0x20] with pc=0x21.
REQ-041 Bench scenario, stall and not-taken branch: stall high for 3 cycles mid-RUN -> instr, pc and cycle_cnt frozen; a branch with taken=0 -> pc increments normally.
REQ-042 Bench scenario, halt: ROM[5]=9'h1F0 -> done=1 and instr_valid=0 the cycle after it is presented, pc=6 holds; a later start -> pc=0, done=0, RUN.
REQ-043 Bench scenario, reset and LUT collision: reset during RUN at pc=7 -> all outputs 0 immediately; a LUT write to entry 3 in the same cycle as a taken branch via entry 3 -> the old target is used.
REQ-044 Bench scenario, wrap: PC_W=4 running to pc=15 -> next pc=0.

Source files
------------

// File: rtl/instr_fetch.sv
// Instruction fetch unit: IDLE/RUN/HALT sequencer driving a program counter into a
// combinational instruction memory, with a writable branch-target LUT for taken branches.
`timescale 1ns/1ps

module instr_fetch #(
  parameter int PC_W  = 10,
  parameter int IW    = 9,
  parameter int LUT_N = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            stall,
  input  logic            branch,
  input  logic            taken,
  input  logic [4:0]      target_idx,
  input  logic            lut_we,
  input  logic [4:0]      lut_waddr,
  input  logic [PC_W-1:0] lut_wdata,
  output logic [PC_W-1:0] imem_addr,
  input  logic [IW-1:0]   imem_data,
  output logic [IW-1:0]   instr,
  output logic            instr_valid,
  output logic [PC_W-1:0] pc,
  output logic            done,
  output logic [15:0]     cycle_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [PC_W-1:0] pc_nxt;
  logic [IW-1:0]   instr_nxt;
  logic            valid_nxt;
  logic            done_nxt;
  logic [15:0]     cnt_nxt;

  logic [PC_W-1:0] lut [LUT_N];
  logic [PC_W-1:0] lut_rd;
  logic            halt_word;

  assign imem_addr = pc;
  // Read sees the pre-write contents, so a same-cycle write to this entry is not forwarded.
  assign lut_rd    = lut[target_idx];
  assign halt_word = (instr[IW-1 -: 5] == 5'b11111);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < LUT_N; i++) begin
        lut[i] <= '0;
      end
    end else if (lut_we) begin
      lut[lut_waddr] <= lut_wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      pc          <= '0;
      instr       <= '0;
      instr_valid <= 1'b0;
      done        <= 1'b0;
      cycle_cnt   <= '0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      instr       <= instr_nxt;
      instr_valid <= valid_nxt;
      done        <= done_nxt;
      cycle_cnt   <= cnt_nxt;
    end
  end

  // Halt outranks a taken branch; a taken branch drops the word fetched alongside it.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    instr_nxt = instr;
    valid_nxt = instr_valid;
    done_nxt  = done;
    cnt_nxt   = cycle_cnt;
    case (state)
      IDLE, HALT: begin
        valid_nxt = 1'b0;
        if (start) begin
          state_nxt = RUN;
          pc_nxt    = '0;
          done_nxt  = 1'b0;
          cnt_nxt   = '0;
        end
      end
      RUN: begin
        if (!stall) begin
          instr_nxt = imem_data;
          if (cycle_cnt != 16'hFFFF) begin
            cnt_nxt = cycle_cnt + 16'd1;
          end
          if (instr_valid && halt_word) begin
            state_nxt = HALT;
            valid_nxt = 1'b0;
            done_nxt  = 1'b1;
          end else if (instr_valid && branch && taken) begin
            pc_nxt    = lut_rd;
            valid_nxt = 1'b0;
          end else begin
            pc_nxt    = pc + PC_W'(1);
            valid_nxt = 1'b1;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        valid_nxt = 1'b0;
      end
    endcase
  end

endmodule
